// File: rtl/lfsr_checker.sv
// Purpose : self-synchronising checker for the x^4+x^3+1 (period 15) PRBS stream; locks, flywheels, counts bit errors.
// Latency : every output is registered; an accepted bit is reflected on all outputs one cycle after its clock edge.
// Backpressure: none; bit_valid low freezes all sequence state, so idle gaps of any length are transparent.
//
// Ports:
//   clk        rising-edge system clock
//   reset      synchronous, active-high; clears every register, overrides all other inputs
//   bit_in     received serial bit, sampled only when bit_valid is high
//   bit_valid  qualifies bit_in
//   err_clr    synchronous clear of err_count (wins over a same-cycle increment)
//   locked     high while in LOCKED
//   err_pulse  one-cycle pulse per mismatch seen in LOCKED
//   err_count  saturating count of LOCKED mismatches since reset / err_clr
//   state      00=HUNT, 01=VERIFY, 10=LOCKED (11 is treated as HUNT)
//   history    last four sequence bits, bit0 = most recent
module lfsr_checker #(
  parameter int SYNC_LEN    = 8,
  parameter int LOSS_THRESH = 3,
  parameter int WINDOW      = 15,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       state,
  output logic [3:0]       history
);

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    VERIFY = 2'b01,
    LOCKED = 2'b10,
    UNUSED = 2'b11
  } state_t;

  localparam logic [7:0]       SYNC_C  = 8'(SYNC_LEN);
  localparam logic [7:0]       LOSS_C  = 8'(LOSS_THRESH);
  localparam logic [7:0]       WIN_C   = 8'(WINDOW);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  // registered state
  state_t           st_q;
  logic [3:0]       hist_q;
  logic [2:0]       fill_q;
  logic [7:0]       match_q;
  logic [7:0]       wcnt_q;
  logic [7:0]       werr_q;
  logic [ERR_W-1:0] errc_q;
  logic             pulse_q;
  logic             locked_q;

  // next-state values
  state_t           st_d;
  logic [3:0]       hist_d;
  logic [2:0]       fill_d;
  logic [7:0]       match_d;
  logic [7:0]       wcnt_d;
  logic [7:0]       werr_d;
  logic [ERR_W-1:0] errc_d;
  logic             pulse_d;
  logic             locked_d;

  // helpers
  logic             pred;
  logic             mism;
  logic             cnt_err;
  logic [3:0]       shift_in;
  logic [2:0]       fill_inc;
  logic [7:0]       match_inc;
  logic [7:0]       wcnt_inc;
  logic [7:0]       werr_tot;

  // b[n] = b[n-3] ^ b[n-4]; with bit0 the newest bit, n-3 is bit2 and n-4 is bit3
  assign pred      = hist_q[2] ^ hist_q[3];
  assign mism      = bit_in ^ pred;
  assign shift_in  = {hist_q[2:0], bit_in};
  assign fill_inc  = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
  assign match_inc = match_q + 8'd1;
  assign wcnt_inc  = wcnt_q + 8'd1;
  // a mismatch on the wrapping bit is charged to the window it closes
  assign werr_tot  = werr_q + {7'd0, mism};

  always_comb begin
    st_d     = st_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    match_d  = match_q;
    wcnt_d   = wcnt_q;
    werr_d   = werr_q;
    errc_d   = errc_q;
    pulse_d  = 1'b0;
    cnt_err  = 1'b0;

    if (bit_valid) begin
      unique case (st_q)
        VERIFY: begin
          hist_d = shift_in;
          if (!mism) begin
            match_d = match_inc;
            if (match_inc == SYNC_C) begin
              st_d   = LOCKED;
              wcnt_d = '0;
              werr_d = '0;
            end
          end else begin
            match_d = '0;
            // all-zero history is the LFSR lock-up state; it can never predict a live stream
            if (shift_in == 4'd0) begin
              st_d   = HUNT;
              fill_d = '0;
            end
          end
        end

        LOCKED: begin
          // flywheel: shift the prediction so one corrupted bit costs exactly one error
          hist_d = {hist_q[2:0], pred};
          if (mism) begin
            cnt_err = 1'b1;
            pulse_d = 1'b1;
          end
          if (werr_tot >= LOSS_C) begin
            st_d   = HUNT;
            fill_d = '0;
            werr_d = werr_tot;
            wcnt_d = wcnt_inc;
          end else if (wcnt_inc == WIN_C) begin
            wcnt_d = '0;
            werr_d = '0;
          end else begin
            wcnt_d = wcnt_inc;
            werr_d = werr_tot;
          end
        end

        // HUNT, and the unused encoding which recovers into HUNT
        default: begin
          st_d   = HUNT;
          hist_d = shift_in;
          fill_d = fill_inc;
          if ((fill_inc == 3'd4) && (shift_in != 4'd0)) begin
            st_d    = VERIFY;
            match_d = '0;
          end
        end
      endcase
    end

    if (err_clr) begin
      errc_d = '0;
    end else if (cnt_err && (errc_q != ERR_MAX)) begin
      errc_d = errc_q + 1'b1;
    end

    locked_d = (st_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q     <= HUNT;
      hist_q   <= '0;
      fill_q   <= '0;
      match_q  <= '0;
      wcnt_q   <= '0;
      werr_q   <= '0;
      errc_q   <= '0;
      pulse_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      wcnt_q   <= wcnt_d;
      werr_q   <= werr_d;
      errc_q   <= errc_d;
      pulse_q  <= pulse_d;
      locked_q <= locked_d;
    end
  end

  assign state     = st_q;
  assign history   = hist_q;
  assign err_count = errc_q;
  assign err_pulse = pulse_q;
  assign locked    = locked_q;

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
Serial receiver/checker for the 4-bit maximal-length pseudo-random bitstream produced by the team's LFSR generator (x^4+x^3+1, period 15). It self-synchronises to the incoming bit stream, declares lock, then flywheels the expected sequence and counts bit errors. It drops lock on an excessive error density. It sits at the consuming end of any serial PRBS link or random-bit path, for link test and for sanity-checking the generator in-system.

Parameters:
SYNC_LEN, 8, consecutive correct predictions required in VERIFY before declaring lock (1..255)
LOSS_THRESH, 3, errors within one window in LOCKED that force return to HUNT (1..WINDOW)
WINDOW, 15, length of the error-density window in valid bits (2..255)
ERR_W, 8, width of the saturating error counter

Ports:
clk  in  1  single system clock, rising edge
reset  in  1  synchronous, active-high; clears all state on the clock edge where it is sampled high
bit_in  in  1  received serial bit
bit_valid  in  1  bit_in is sampled only when high; all state is frozen when low
err_clr  in  1  synchronous clear of err_count
locked  out  1  high while in LOCKED
err_pulse  out  1  one-cycle pulse per mismatch detected in LOCKED
err_count  out  ERR_W  saturating count of LOCKED mismatches since reset or err_clr
state  out  2  00=HUNT, 01=VERIFY, 10=LOCKED (11 unused, decodes to HUNT)
history  out  4  last four bits in the history register, bit0 = most recent

Behaviour:
- Sequence law: b[n] = b[n-3] XOR b[n-4]. The prediction is history[2] ^ history[3].
- All outputs are registered. Each update occurs on a clock edge with bit_valid=1 and is visible the following cycle.
- Reset values: state=HUNT, locked=0, err_pulse=0, err_count=0, history=0, fill=0, match count=0, window count=0, window errors=0. Reset has priority over every other input, including mid-lock; nothing is retained.
- err_pulse deasserts on any cycle with no mismatch, including cycles with bit_valid=0.
- HUNT:
  - Shift bit_in into history and increment fill, saturating at 4.
  - When fill=4 and the updated history is nonzero, go to VERIFY with match count 0.
  - An all-zero history never leaves HUNT (zero lock-up state).
- VERIFY:
  - Compare bit_in against the prediction. History always takes bit_in.
  - On a match, increment the match count. On reaching SYNC_LEN, go to LOCKED with window count and window errors cleared.
  - On a mismatch, clear the match count. If the updated history is all-zero, go to HUNT with fill=0. No err_pulse and no err_count change in VERIFY.
- LOCKED (flywheel):
  - History shifts in the predicted bit, not bit_in, so a single corrupted bit costs exactly one error.
  - On a mismatch: err_pulse=1, err_count+1 (saturates at 2^ERR_W-1), window errors+1.
  - If window errors reach LOSS_THRESH: go to HUNT, fill=0, locked drops next cycle, err_count retained.
  - Window count increments per valid bit. When it reaches WINDOW, it wraps to 0 and window errors clear. A mismatch on the wrapping bit is counted in the old window first, and the threshold check uses that total.
- err_clr: err_count becomes 0. It has priority over a same-cycle increment. err_pulse still fires for that mismatch.
- Gaps in bit_valid of any length are transparent; the sequence continues from the last valid bit.

Test Plan:
- Reset: drive reset=1 for 2 cycles with random bit_in and bit_valid=1 -> state=00, locked=0, err_count=0, history=0000, err_pulse=0.
- Clean lock: feed 0,0,1,1,0,1,0,1,1,1,1,0,0,0,1 repeating with bit_valid=1 -> state=01 after bit 4. Locked rises the cycle after bit 12 (4 fill + 8 matches). It stays high for 60 further bits with err_count=0.
- Single error: once locked, invert one bit -> exactly one err_pulse. err_count=1, locked stays 1. Following correct bits produce no further errors (flywheel).
- Lock loss: while locked, invert 3 bits within 15 valid bits -> third error gives err_pulse. State=HUNT and locked=0 next cycle, err_count=3. Correct stream afterwards relocks after 12 more bits.
- All-zero input: 40 bits of 0 -> state remains HUNT, locked never asserts.
- Edge cases:
  - Insert random bit_valid=0 gaps into the clean stream -> same lock point counted in valid bits.
  - err_clr coincident with an error -> err_count=0, err_pulse=1.
  - Force 300 errors with ERR_W=8 -> err_count saturates at 255.
  - reset mid-LOCKED -> all outputs return to reset values.
